// File: rtl/riscv_irq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_irq_arbiter_pkg
// Purpose : Shared constants and types for the interrupt arbiter front-end:
//           line count, id width, config register addresses, FSM states.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package riscv_irq_arbiter_pkg;

  localparam int IRQ_NUM  = 32;
  localparam int IRQ_ID_W = 5;

  // Register file addresses
  localparam logic [1:0] IRQ_CFG_MASK    = 2'd0;
  localparam logic [1:0] IRQ_CFG_PENDING = 2'd1;
  localparam logic [1:0] IRQ_CFG_SECURE  = 2'd2;
  localparam logic [1:0] IRQ_CFG_EDGE    = 2'd3;

  typedef enum logic [0:0] {
    IRQ_ST_IDLE  = 1'b0,
    IRQ_ST_GUARD = 1'b1
  } irq_state_e;

endpackage
`default_nettype wire

// File: rtl/riscv_irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module  : riscv_irq_prio_enc
// Purpose : Highest-set-bit encoder over the interrupt candidate vector.
//           Bit 31 has the highest priority.
// Ports   : req_i   [31:0] candidate vector
//           id_o    [4:0]  index of highest set bit (0 when none set)
//           valid_o        at least one bit set
// Revision: 1.0 - initial release
// ============================================================================
module riscv_irq_prio_enc
  import riscv_irq_arbiter_pkg::*;
(
  input  logic [IRQ_NUM-1:0]  req_i,
  output logic [IRQ_ID_W-1:0] id_o,
  output logic                valid_o
);

  // Ascending scan: later (higher) indices overwrite earlier ones.
  always_comb begin
    id_o    = '0;
    valid_o = 1'b0;
    for (int k = 0; k < IRQ_NUM; k++) begin
      if (req_i[k]) begin
        id_o    = IRQ_ID_W'(k);
        valid_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : riscv_irq_arbiter
// Purpose : Interrupt front-end. Synchronises 32 lines, latches level/edge
//           events into PENDING, masks and priority-encodes them, and holds
//           off the request for one cycle after each acknowledge.
// Ports   : clk, rst_n (async, active-low), setback_i (sync soft reset)
//           irq_lines_i[31:0]           raw sources, bit k = id k
//           irq_ack_i, irq_ack_id_i[4:0] core acknowledge
//           cfg_we_i, cfg_addr_i[1:0], cfg_wdata_i[31:0], cfg_rdata_o[31:0]
//           irq_o, irq_id_o[4:0], irq_sec_o   request to the controller
// Revision: 1.0 - initial release
// ============================================================================
module riscv_irq_arbiter
  import riscv_irq_arbiter_pkg::*;
#(
  parameter int PULP_SECURE = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                setback_i,
  input  logic [IRQ_NUM-1:0]  irq_lines_i,
  input  logic                irq_ack_i,
  input  logic [IRQ_ID_W-1:0] irq_ack_id_i,
  input  logic                cfg_we_i,
  input  logic [1:0]          cfg_addr_i,
  input  logic [31:0]         cfg_wdata_i,
  output logic [31:0]         cfg_rdata_o,
  output logic                irq_o,
  output logic [IRQ_ID_W-1:0] irq_id_o,
  output logic                irq_sec_o
);

  logic [IRQ_NUM-1:0] sync_s;
  logic [IRQ_NUM-1:0] sync_prev_q;
  logic [IRQ_NUM-1:0] mask_q, mask_d;
  logic [IRQ_NUM-1:0] pend_q, pend_d;
  logic [IRQ_NUM-1:0] sec_q, sec_d;
  logic [IRQ_NUM-1:0] edge_q, edge_d;
  irq_state_e         state_q, state_d;

  logic               ack_take;
  logic [IRQ_NUM-1:0] rise;
  logic [IRQ_NUM-1:0] ack_clr;
  logic [IRQ_NUM-1:0] w1c_clr;
  logic [IRQ_NUM-1:0] cand;
  logic [IRQ_ID_W-1:0] sel_id;
  logic               sel_valid;

  // --------------------------------------------------------------------------
  // Input synchroniser
  // --------------------------------------------------------------------------
  if (SYNC_STAGES == 0) begin : g_no_sync
    assign sync_s = irq_lines_i;
  end else begin : g_sync
    logic [IRQ_NUM-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else if (setback_i) begin
        for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= irq_lines_i;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];
  end

  // --------------------------------------------------------------------------
  // Configuration registers
  // --------------------------------------------------------------------------
  always_comb begin
    mask_d = mask_q;
    sec_d  = sec_q;
    edge_d = edge_q;
    if (cfg_we_i) begin
      case (cfg_addr_i)
        IRQ_CFG_MASK:   mask_d = cfg_wdata_i;
        IRQ_CFG_SECURE: if (PULP_SECURE != 0) sec_d = cfg_wdata_i;
        IRQ_CFG_EDGE:   edge_d = cfg_wdata_i;
        default:        ; // PENDING is write-one-to-clear, handled below
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Pending: level lines track the synchronised input; edge lines latch a
  // rising edge, which wins over a same-cycle ack or W1C clear.
  // --------------------------------------------------------------------------
  assign rise    = sync_s & ~sync_prev_q;
  assign ack_clr = ack_take ? (IRQ_NUM'(1) << irq_ack_id_i) : '0;
  assign w1c_clr = (cfg_we_i && (cfg_addr_i == IRQ_CFG_PENDING)) ? cfg_wdata_i : '0;
  assign pend_d  = (~edge_q & sync_s)
                 | ( edge_q & (rise | (pend_q & ~ack_clr & ~w1c_clr)));

  // --------------------------------------------------------------------------
  // Ack FSM: GUARD masks the request for the controller's IRQ_DONE cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ack_take = 1'b0;
    case (state_q)
      IRQ_ST_IDLE: begin
        if (irq_ack_i) begin
          ack_take = 1'b1;
          state_d  = IRQ_ST_GUARD;
        end
      end
      IRQ_ST_GUARD: state_d = IRQ_ST_IDLE;
      default:      state_d = IRQ_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_prev_q <= '0;
      mask_q      <= '0;
      pend_q      <= '0;
      sec_q       <= '0;
      edge_q      <= '0;
      state_q     <= IRQ_ST_IDLE;
    end else if (setback_i) begin
      sync_prev_q <= '0;
      mask_q      <= '0;
      pend_q      <= '0;
      sec_q       <= '0;
      edge_q      <= '0;
      state_q     <= IRQ_ST_IDLE;
    end else begin
      sync_prev_q <= sync_s;
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      sec_q       <= sec_d;
      edge_q      <= edge_d;
      state_q     <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Selection and outputs (combinational from registers)
  // --------------------------------------------------------------------------
  assign cand = pend_q & mask_q;

  riscv_irq_prio_enc u_prio_enc (
    .req_i   (cand),
    .id_o    (sel_id),
    .valid_o (sel_valid)
  );

  assign irq_o     = sel_valid && (state_q == IRQ_ST_IDLE);
  assign irq_id_o  = sel_id;
  assign irq_sec_o = (PULP_SECURE != 0) ? (sec_q[sel_id] & irq_o) : 1'b0;

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      IRQ_CFG_MASK:    cfg_rdata_o = mask_q;
      IRQ_CFG_PENDING: cfg_rdata_o = pend_q;
      IRQ_CFG_SECURE:  cfg_rdata_o = (PULP_SECURE != 0) ? sec_q : '0;
      IRQ_CFG_EDGE:    cfg_rdata_o = edge_q;
      default:         cfg_rdata_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_riscv_irq_arbiter
// Purpose : Self-checking bench for riscv_irq_arbiter. Expected outputs are
//           queued with a due cycle when stimulus is driven and compared on
//           the falling edge of that cycle. A second instance with
//           PULP_SECURE=0 shares all inputs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_riscv_irq_arbiter;
  import riscv_irq_arbiter_pkg::*;

  localparam int S_IRQ    = 0;
  localparam int S_ID     = 1;
  localparam int S_SEC    = 2;
  localparam int S_RD     = 3;
  localparam int S_NS_SEC = 4;
  localparam int S_NS_RD  = 5;
  localparam int S_NS_IRQ = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        setback;
  logic [31:0] lines;
  logic        ack;
  logic [4:0]  ack_id;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata, ns_rdata;
  logic        irq, ns_irq;
  logic [4:0]  irq_id, ns_irq_id;
  logic        irq_sec, ns_irq_sec;

  int cyc     = 0;
  int n_check = 0;
  int n_fail  = 0;

  typedef struct {
    int          due;
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_irq_arbiter #(.PULP_SECURE(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .setback_i(setback), .irq_lines_i(lines),
    .irq_ack_i(ack), .irq_ack_id_i(ack_id), .cfg_we_i(we), .cfg_addr_i(addr),
    .cfg_wdata_i(wdata), .cfg_rdata_o(rdata), .irq_o(irq), .irq_id_o(irq_id),
    .irq_sec_o(irq_sec)
  );

  riscv_irq_arbiter #(.PULP_SECURE(0), .SYNC_STAGES(2)) dut_ns (
    .clk(clk), .rst_n(rst_n), .setback_i(setback), .irq_lines_i(lines),
    .irq_ack_i(ack), .irq_ack_id_i(ack_id), .cfg_we_i(we), .cfg_addr_i(addr),
    .cfg_wdata_i(wdata), .cfg_rdata_o(ns_rdata), .irq_o(ns_irq),
    .irq_id_o(ns_irq_id), .irq_sec_o(ns_irq_sec)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_IRQ:    return {31'b0, irq};
      S_ID:     return {27'b0, irq_id};
      S_SEC:    return {31'b0, irq_sec};
      S_RD:     return rdata;
      S_NS_SEC: return {31'b0, ns_irq_sec};
      S_NS_RD:  return ns_rdata;
      S_NS_IRQ: return {31'b0, ns_irq};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Scoreboard consumer: compare every entry due this cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due <= cyc) begin
        chk(sb_q[i].tag, observe(sb_q[i].sel), sb_q[i].exp);
        sb_q.delete(i);
      end
    end
  end

  task automatic exp_at(input string tag, input int sel, input logic [31:0] val, input int d);
    exp_t e;
    e.due = cyc + d;
    e.tag = tag;
    e.sel = sel;
    e.exp = val;
    sb_q.push_back(e);
  endtask

  task automatic exp_now(input string tag, input int sel, input logic [31:0] val);
    exp_at(tag, sel, val, 0);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; setback = 1'b0; lines = '0; ack = 1'b0; ack_id = '0;
    we = 1'b0; addr = IRQ_CFG_MASK; wdata = '0;

    // ---- reset state ----
    step();
    exp_now("rst_irq", S_IRQ, 0);
    exp_now("rst_id",  S_ID,  0);
    exp_now("rst_sec", S_SEC, 0);
    exp_now("rst_mask_rd", S_RD, 0);
    step();
    addr = IRQ_CFG_PENDING;
    exp_now("rst_pend_rd", S_RD, 0);
    step();
    rst_n = 1'b1;
    step(2);

    // ---- t1: edge on line 0, latency, hold, ack, GUARD ----
    cfg_write(IRQ_CFG_EDGE, 32'h1);
    cfg_write(IRQ_CFG_MASK, 32'h1);
    lines = 32'h1;
    exp_at("t1_early", S_IRQ, 0, 2);
    exp_at("t1_lat",   S_IRQ, 1, 3);
    exp_at("t1_id",    S_ID,  0, 3);
    step(); lines = '0;
    step(4);
    exp_now("t1_hold", S_IRQ, 1);
    ack = 1'b1; ack_id = 5'd0; addr = IRQ_CFG_PENDING;
    exp_at("t1_guard",    S_IRQ, 0, 1);
    exp_at("t1_pend_clr", S_RD,  0, 1);
    exp_at("t1_after",    S_IRQ, 0, 2);
    step(); ack = 1'b0;
    step(3);

    // ---- t2: level lines 3 and 20, priority, drop, ack no effect ----
    cfg_write(IRQ_CFG_EDGE, 32'h0);
    cfg_write(IRQ_CFG_MASK, 32'hFFFF_FFFF);
    lines = 32'h0010_0008;
    exp_at("t2_irq",  S_IRQ, 1,  3);
    exp_at("t2_id20", S_ID,  20, 3);
    step(4);
    lines = 32'h0000_0008;
    exp_at("t2_id20_hold", S_ID, 20, 2);
    exp_at("t2_id3",       S_ID, 3,  3);
    step(3);
    ack = 1'b1; ack_id = 5'd3; addr = IRQ_CFG_PENDING;
    exp_at("t2_guard",      S_IRQ, 0,        1);
    exp_at("t2_pend_level", S_RD,  32'h8,    1);
    exp_at("t2_reassert",   S_IRQ, 1,        2);
    step(); ack = 1'b0;
    step();
    lines = '0;
    step(4);

    // ---- t3: secure attribute ----
    cfg_write(IRQ_CFG_SECURE, 32'h0010_0000);
    cfg_write(IRQ_CFG_EDGE, 32'hFFFF_FFFF);
    addr = IRQ_CFG_SECURE;
    exp_now("t3_sec_rd",    S_RD,    32'h0010_0000);
    exp_now("t3_ns_sec_rd", S_NS_RD, 32'h0);
    lines = 32'h0010_0000;
    exp_at("t3_irq20",    S_IRQ,    1,  3);
    exp_at("t3_id20",     S_ID,     20, 3);
    exp_at("t3_sec20",    S_SEC,    1,  3);
    exp_at("t3_ns_irq",   S_NS_IRQ, 1,  3);
    exp_at("t3_ns_sec20", S_NS_SEC, 0,  3);
    step(); lines = '0;
    step(2);
    ack = 1'b1; ack_id = 5'd20;
    exp_at("t3_guard_sec", S_SEC, 0, 1);
    step(); ack = 1'b0;
    step();
    lines = 32'h0000_0020;
    exp_at("t3_irq5", S_IRQ, 1, 3);
    exp_at("t3_id5",  S_ID,  5, 3);
    exp_at("t3_sec5", S_SEC, 0, 3);
    step(); lines = '0;
    step(2);
    ack = 1'b1; ack_id = 5'd5;
    step(); ack = 1'b0;
    step(2);

    // ---- t4: new edge on line 7 in the same cycle as its ack ----
    lines = 32'h0000_0080;
    exp_at("t4_first", S_ID, 7, 3);
    step(); lines = '0;
    step(2);
    lines = 32'h0000_0080;
    step(); lines = '0;
    step();
    ack = 1'b1; ack_id = 5'd7; addr = IRQ_CFG_PENDING;
    exp_at("t4_guard",     S_IRQ, 0,     1);
    exp_at("t4_pend_kept", S_RD,  32'h80, 1);
    exp_at("t4_reassert",  S_IRQ, 1,     2);
    exp_at("t4_id",        S_ID,  7,     2);
    step(); ack = 1'b0;
    step();
    ack = 1'b1; ack_id = 5'd7;
    exp_at("t4_clear", S_RD, 0, 1);
    step(); ack = 1'b0;
    step(2);

    // ---- t5: masking hides, unmask re-presents, W1C clears ----
    cfg_write(IRQ_CFG_MASK, 32'h0);
    addr = IRQ_CFG_PENDING;
    lines = 32'h0000_0200;
    exp_at("t5_masked_irq", S_IRQ, 0,      3);
    exp_at("t5_masked_pnd", S_RD,  32'h200, 3);
    step(); lines = '0;
    step(3);
    exp_at("t5_unmask_irq", S_IRQ, 1, 1);
    exp_at("t5_unmask_id",  S_ID,  9, 1);
    cfg_write(IRQ_CFG_MASK, 32'h200);
    exp_at("t5_w1c_irq", S_IRQ, 0, 1);
    cfg_write(IRQ_CFG_PENDING, 32'h200);
    exp_now("t5_w1c_pend", S_RD, 0);
    step(2);

    // ---- t6: ack in GUARD ignored, foreign ack id, setback in GUARD ----
    cfg_write(IRQ_CFG_MASK, 32'hFFFF_FFFF);
    addr = IRQ_CFG_PENDING;
    lines = 32'h4000_0004;
    exp_at("t6_id30", S_ID, 30, 3);
    step(); lines = '0;
    step(2);
    ack = 1'b1; ack_id = 5'd30;
    step();
    ack_id = 5'd2;
    exp_at("t6_guard_ack_pnd", S_RD,  32'h4, 1);
    exp_at("t6_guard_ack_id",  S_ID,  2,     1);
    exp_at("t6_guard_ack_irq", S_IRQ, 1,     1);
    step(); ack = 1'b0;
    lines = 32'h4000_0000;
    exp_at("t6_both", S_RD, 32'h4000_0004, 3);
    step(); lines = '0;
    step(2);
    ack = 1'b1; ack_id = 5'd5;
    exp_at("t6_other_id_pnd", S_RD,  32'h4000_0004, 1);
    exp_at("t6_other_id_irq", S_IRQ, 0,             1);
    step(); ack = 1'b0;
    setback = 1'b1;
    exp_at("t6_sb_pend", S_RD,  0, 1);
    exp_at("t6_sb_irq",  S_IRQ, 0, 1);
    exp_at("t6_sb_id",   S_ID,  0, 1);
    step(); setback = 1'b0;
    step();
    addr = IRQ_CFG_MASK;
    exp_now("t6_sb_mask", S_RD, 0);
    step();
    addr = IRQ_CFG_EDGE;
    exp_now("t6_sb_edge", S_RD, 0);
    step();
    addr = IRQ_CFG_SECURE;
    exp_now("t6_sb_sec", S_RD, 0);
    step(2);

    // ---- drain scoreboard ----
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    chk("sb_drain", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
